// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period derivation,
// common to the receiver and the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_RECV   = 3'd2,
      ST_STOP   = 3'd3,
      ST_PARITY = 3'd4
   } uart_state_t;

   function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
      return clk_hz / bit_rate;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset
// value is a parameter so an idle-high line does not look like a start bit.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit glitch rejection, mid-bit sampling, framing/break
// detection. Optional even parity enabled by defining UART_RX_PARITY_EN.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BIT_RATE     = 9600,
   parameter int CLK_HZ       = 50_000_000,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    uart_rxd,
   input  logic                    uart_rx_en,
   output logic                    uart_rx_valid,
   output logic [PAYLOAD_BITS-1:0] uart_rx_data,
   output logic                    uart_rx_frame_err,
   output logic                    uart_rx_break
`ifdef UART_RX_PARITY_EN
   ,
   output logic                    uart_rx_parity_err
`endif
);

   localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
   localparam int CNT_W          = $clog2(CYCLES_PER_BIT) + 1;
   localparam int BIT_MAX        = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
   localparam int BIT_W          = $clog2(BIT_MAX) + 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [BIT_W-1:0] PAY_LAST  = BIT_W'(PAYLOAD_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   logic rxd;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (uart_rxd),
      .q      (rxd)
   );

   uart_state_t             state, state_nxt;
   logic [CNT_W-1:0]        cyc_cnt, cyc_nxt;
   logic [BIT_W-1:0]        bit_cnt, bit_nxt;
   logic [PAYLOAD_BITS-1:0] shift, shift_nxt;
   logic [PAYLOAD_BITS-1:0] data, data_nxt;
   logic                    stop_ok, stop_ok_nxt;
   logic                    valid, valid_nxt;
   logic                    ferr, ferr_nxt;
   logic                    brk, brk_nxt;
   logic                    mid_bit;
   logic                    frame_ok;
`ifdef UART_RX_PARITY_EN
   logic                    par_bad, par_bad_nxt;
   logic                    perr, perr_nxt;
`endif

   assign mid_bit  = (cyc_cnt == BIT_LAST);
   assign frame_ok = stop_ok & rxd;

   always_comb begin
      state_nxt   = state;
      cyc_nxt     = cyc_cnt + CNT_W'(1);
      bit_nxt     = bit_cnt;
      shift_nxt   = shift;
      data_nxt    = data;
      stop_ok_nxt = stop_ok;
      valid_nxt   = 1'b0;
      ferr_nxt    = 1'b0;
      brk_nxt     = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_nxt = par_bad;
      perr_nxt    = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            cyc_nxt     = '0;
            bit_nxt     = '0;
            stop_ok_nxt = 1'b1;
            if (!rxd && uart_rx_en) state_nxt = ST_START;
         end
         ST_START: begin
            // A start bit that is high again by its midpoint was a glitch.
            if (cyc_cnt == HALF_LAST) begin
               cyc_nxt   = '0;
               state_nxt = rxd ? ST_IDLE : ST_RECV;
            end
         end
         ST_RECV: begin
            if (mid_bit) begin
               cyc_nxt   = '0;
               shift_nxt = PAYLOAD_BITS'({rxd, shift} >> 1);
               if (bit_cnt == PAY_LAST) begin
                  bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end else begin
                  bit_nxt = bit_cnt + BIT_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (mid_bit) begin
               cyc_nxt     = '0;
               par_bad_nxt = rxd ^ (^shift);
               state_nxt   = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (mid_bit) begin
               cyc_nxt     = '0;
               stop_ok_nxt = frame_ok;
               if (bit_cnt == STOP_LAST) begin
                  state_nxt = ST_IDLE;
                  ferr_nxt  = ~frame_ok;
                  brk_nxt   = ~frame_ok && (shift == '0);
`ifdef UART_RX_PARITY_EN
                  perr_nxt  = par_bad;
                  valid_nxt = frame_ok & ~par_bad;
                  if (frame_ok && !par_bad) data_nxt = shift;
`else
                  valid_nxt = frame_ok;
                  if (frame_ok) data_nxt = shift;
`endif
               end else begin
                  bit_nxt = bit_cnt + BIT_W'(1);
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cyc_nxt   = '0;
            bit_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         cyc_cnt <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         data    <= '0;
         stop_ok <= 1'b1;
         valid   <= 1'b0;
         ferr    <= 1'b0;
         brk     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad <= 1'b0;
         perr    <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         cyc_cnt <= cyc_nxt;
         bit_cnt <= bit_nxt;
         shift   <= shift_nxt;
         data    <= data_nxt;
         stop_ok <= stop_ok_nxt;
         valid   <= valid_nxt;
         ferr    <= ferr_nxt;
         brk     <= brk_nxt;
`ifdef UART_RX_PARITY_EN
         par_bad <= par_bad_nxt;
         perr    <= perr_nxt;
`endif
      end
   end

   assign uart_rx_valid     = valid;
   assign uart_rx_data      = data;
   assign uart_rx_frame_err = ferr;
   assign uart_rx_break     = brk;
`ifdef UART_RX_PARITY_EN
   assign uart_rx_parity_err = perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; expected output events are
// queued as frames are driven and matched when the receiver pulses.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPB = 10;

   logic       clk;
   logic       resetn;
   logic       uart_rxd;
   logic       uart_rx_en;
   logic       uart_rx_valid;
   logic [7:0] uart_rx_data;
   logic       uart_rx_frame_err;
   logic       uart_rx_break;
`ifdef UART_RX_PARITY_EN
   logic       uart_rx_parity_err;
`endif

   uart_rx #(
      .BIT_RATE     (100_000),
      .CLK_HZ       (1_000_000),
      .PAYLOAD_BITS (8),
      .STOP_BITS    (1)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .uart_rxd          (uart_rxd),
      .uart_rx_en        (uart_rx_en),
      .uart_rx_valid     (uart_rx_valid),
      .uart_rx_data      (uart_rx_data),
      .uart_rx_frame_err (uart_rx_frame_err),
      .uart_rx_break     (uart_rx_break)
`ifdef UART_RX_PARITY_EN
      ,
      .uart_rx_parity_err (uart_rx_parity_err)
`endif
   );

   typedef struct {
      logic       v;
      logic       fe;
      logic       brk;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   exp_t       got;
   logic [7:0] last_good;
   int         tests = 0;
   int         fails = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic b, input int n);
      uart_rxd = b;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      exp_t e;
      e.v    = stop;
      e.fe   = ~stop;
      e.brk  = ~stop && (d == 8'h00);
      if (stop) last_good = d;
      e.data = last_good;
      sb.push_back(e);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
      hold(^d, CPB);
`endif
      hold(stop, CPB);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (resetn && (uart_rx_valid || uart_rx_frame_err || uart_rx_break)) begin
         if (sb.size() == 0) begin
            check("spurious_pulse", 32'({uart_rx_frame_err, uart_rx_break, uart_rx_valid}), 32'd0);
         end else begin
            got = sb.pop_front();
            check("valid", 32'(uart_rx_valid), 32'(got.v));
            check("frame_err", 32'(uart_rx_frame_err), 32'(got.fe));
            check("break", 32'(uart_rx_break), 32'(got.brk));
            check("data", 32'(uart_rx_data), 32'(got.data));
         end
      end
`ifdef UART_RX_PARITY_EN
      if (resetn && uart_rx_parity_err) check("parity_err", 32'(uart_rx_parity_err), 32'd0);
`endif
   end

   initial begin
      last_good  = 8'h00;
      resetn     = 1'b0;
      uart_rxd   = 1'b1;
      uart_rx_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(uart_rx_valid), 32'd0);
      check("rst_frame_err", 32'(uart_rx_frame_err), 32'd0);
      check("rst_break", 32'(uart_rx_break), 32'd0);
      check("rst_data", 32'(uart_rx_data), 32'd0);
      check("rst_state", 32'(dut.state), 32'(ST_IDLE));
      resetn = 1'b1;
      hold(1'b1, 20);

      // single good frame
      send_frame(8'hA5, 1'b1);
      hold(1'b1, 10);
      wait_drain("drain_a5", 40);

      // back-to-back frames with no idle gap
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      hold(1'b1, 10);
      wait_drain("drain_b2b", 40);

      // 3-cycle low glitch on an idle line
      hold(1'b0, 3);
      hold(1'b1, 10);
      check("glitch_idle", 32'(dut.state), 32'(ST_IDLE));
      hold(1'b1, 20);

      // bad stop bit keeps the previous data
      send_frame(8'h3C, 1'b0);
      hold(1'b1, 20);
      wait_drain("drain_ferr", 40);
      check("ferr_data_kept", 32'(uart_rx_data), 32'h0000_00FF);

      // 15 bit times of break; enable dropped mid-frame so only one frame is taken
      begin
         exp_t e;
         e.v = 1'b0; e.fe = 1'b1; e.brk = 1'b1; e.data = last_good;
         sb.push_back(e);
      end
      hold(1'b0, 60);
      uart_rx_en = 1'b0;
      hold(1'b0, 90);
      hold(1'b1, 20);
      uart_rx_en = 1'b1;
      wait_drain("drain_break", 40);
      hold(1'b1, 20);

      // reset during bit 4 of 0x5A discards the frame
      hold(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold(((8'h5A >> i) & 8'h01) != 8'h00, CPB);
      hold(1'b1, 5);
      resetn = 1'b0;
      hold(1'b1, 2);
      check("midrst_data", 32'(uart_rx_data), 32'd0);
      check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
      resetn    = 1'b1;
      last_good = 8'h00;
      hold(1'b1, 30);
      check("post_rst_queue", 32'(sb.size()), 32'd0);
      send_frame(8'h81, 1'b1);
      hold(1'b1, 10);
      wait_drain("drain_81", 40);
      hold(1'b1, 30);
      check("final_data_hold", 32'(uart_rx_data), 32'h0000_0081);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
